// File: rtl/vc_arbiter_pkg.sv
// vc_arbiter_pkg: shared defaults and FSM state encoding for the VC arbiter
package vc_arbiter_pkg;
  localparam int DATA_W_DEF        = 6;
  localparam int DEST_BIT_DEF      = 4;
  localparam int MAX_VC0_BURST_DEF = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;
endpackage

// File: rtl/vc_arbiter_sat_counter.sv
// sat_counter: counter with clear priority over increment, saturating at MAX
module sat_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/vc_arbiter.sv
// vc_arbiter: moves VC0/VC1 head words to D0/D1 with VC0 priority and a VC0 burst limit
module vc_arbiter import vc_arbiter_pkg::*; #(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DEST_BIT      = DEST_BIT_DEF,
  parameter int MAX_VC0_BURST = MAX_VC0_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vc0_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_pause,
  input  logic              d1_pause,
  output logic              pop_vc0,
  output logic              pop_vc1,
  output logic              push_d0,
  output logic              push_d1,
  output logic [DATA_W-1:0] data_out,
  output logic              idle_out
);
  localparam int CW = $clog2(MAX_VC0_BURST) + 1;
  logic              act, elig0, elig1, grant0, grant1, any;
  logic [CW-1:0]     burst_cnt;
  logic [DATA_W-1:0] word, data_q;
  logic              push_d0_q, push_d1_q, idle_q;
  state_e            state_q, state_d;
  assign act    = enable & ~reset;
  assign elig0  = act & ~vc0_empty & ~(vc0_data[DEST_BIT] ? d1_pause : d0_pause);
  assign elig1  = act & ~vc1_empty & ~(vc1_data[DEST_BIT] ? d1_pause : d0_pause);
  assign grant0 = elig0 & (~elig1 | (burst_cnt < CW'(MAX_VC0_BURST)));
  assign grant1 = elig1 & ~grant0;
  assign any    = grant0 | grant1;
  assign word   = grant0 ? vc0_data : vc1_data;
  // counter is frozen while disabled so a re-enable resumes the same burst
  sat_counter #(.MAX(MAX_VC0_BURST), .W(CW)) u_burst (
    .clk   (clk),
    .reset (reset),
    .inc_i (grant0 & elig1),
    .clr_i (enable & (grant1 | ~elig1)),
    .cnt_o (burst_cnt)
  );
  always_comb state_d = any ? ST_ACTIVE : (push_d0_q | push_d1_q) ? state_q : ST_IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_q    <= '0;
      state_q   <= ST_IDLE;
      idle_q    <= 1'b1;
    end else begin
      push_d0_q <= any & ~word[DEST_BIT];
      push_d1_q <= any & word[DEST_BIT];
      if (any) data_q <= word;
      state_q   <= state_d;
      idle_q    <= state_d == ST_IDLE;
    end
  end
  assign pop_vc0  = grant0;
  assign pop_vc1  = grant1;
  assign push_d0  = push_d0_q;
  assign push_d1  = push_d1_q;
  assign data_out = data_q;
  assign idle_out = idle_q;
endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: queue-based reference model with directed and random stimulus
module tb_vc_arbiter;
  localparam int DW = 6, DB = 4, MB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, vc0_empty = 1'b1, vc1_empty = 1'b1, d0_pause = 1'b0, d1_pause = 1'b0;
  logic [DW-1:0] vc0_data = '0, vc1_data = '0, data_out;
  logic pop_vc0, pop_vc1, push_d0, push_d1, idle_out;
  int total = 0, bad = 0;
  logic [DW-1:0] q0[$], q1[$];
  int m_burst = 0;
  bit m_push0 = 0, m_push1 = 0, m_active = 0, m_idle = 1;
  logic [DW-1:0] m_data = '0;
  bit s_pop0, s_pop1;

  always #5 clk = ~clk;

  vc_arbiter #(.DATA_W(DW), .DEST_BIT(DB), .MAX_VC0_BURST(MB)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .vc0_empty(vc0_empty), .vc0_data(vc0_data),
    .vc1_empty(vc1_empty), .vc1_data(vc1_data),
    .d0_pause(d0_pause), .d1_pause(d1_pause),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .idle_out(idle_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // one clock: drive at negedge, compare, then advance the model at posedge
  task automatic step(input bit rst, input bit en, input bit p0, input bit p1);
    bit e0, e1, g0, g1, was_push;
    logic [DW-1:0] h0, h1;
    @(negedge clk);
    h0 = (q0.size() != 0) ? q0[0] : DW'($urandom);
    h1 = (q1.size() != 0) ? q1[0] : DW'($urandom);
    reset = rst; enable = en; d0_pause = p0; d1_pause = p1;
    vc0_empty = q0.size() == 0; vc1_empty = q1.size() == 0;
    vc0_data = h0; vc1_data = h1;
    #1;
    e0 = !rst && en && q0.size() != 0 && !(h0[DB] ? p1 : p0);
    e1 = !rst && en && q1.size() != 0 && !(h1[DB] ? p1 : p0);
    g0 = e0 && (!e1 || m_burst < MB);
    g1 = e1 && !g0;
    s_pop0 = pop_vc0; s_pop1 = pop_vc1;
    check("pop_vc0", pop_vc0, g0);
    check("pop_vc1", pop_vc1, g1);
    check("push_d0", push_d0, m_push0);
    check("push_d1", push_d1, m_push1);
    check("data_out", data_out, m_data);
    check("idle_out", idle_out, m_idle);
    @(posedge clk);
    if (rst) begin
      m_push0 = 0; m_push1 = 0; m_data = '0; m_burst = 0; m_active = 0; m_idle = 1;
    end else begin
      was_push = m_push0 || m_push1;
      if (en) begin
        if (g1 || !e1) m_burst = 0;
        else if (g0 && m_burst < MB) m_burst++;
      end
      m_push0 = (g0 && !h0[DB]) || (g1 && !h1[DB]);
      m_push1 = (g0 && h0[DB]) || (g1 && h1[DB]);
      if (g0) m_data = h0;
      else if (g1) m_data = h1;
      if (g0 || g1) m_active = 1;
      else if (!was_push) m_active = 0;
      m_idle = !m_active;
      if (g0) void'(q0.pop_front());
      if (g1) void'(q1.pop_front());
    end
  endtask

  initial begin
    // reset held with VC0 non-empty
    q0 = '{6'h01};
    repeat (3) step(1, 1, 0, 0);
    check("t1_idle", idle_out, 1);
    q0.delete();
    // three VC0 words to D0, then drain to idle
    q0 = '{6'h01, 6'h02, 6'h03};
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0);
    check("t2_data", data_out, 6'h03);
    check("t2_idle", idle_out, 1);
    // both VCs full, same destination: 4xVC0 then 1xVC1
    step(1, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin q0.push_back(6'h0A); q1.push_back(6'h0B); end
    for (int k = 0; k < 15; k++) begin
      step(0, 1, 0, 0);
      check("t3_pat", s_pop1, (k % 5) == 4);
      check("t3_busy", s_pop0 | s_pop1, 1);
    end
    q0.delete(); q1.delete();
    // paused D0 head on VC0 does not block VC1 going to D1
    step(1, 1, 0, 0);
    q0 = '{6'h01}; q1 = '{6'h30};
    step(0, 1, 1, 0);
    check("t4_pop1", s_pop1, 1);
    step(0, 1, 1, 0);
    check("t4_push1", push_d1, 1);
    check("t4_data", data_out, 6'h30);
    check("t4_hold0", s_pop0, 0);
    step(0, 1, 0, 0);
    check("t4_pop0", s_pop0, 1);
    // enable drops right after a grant
    step(1, 1, 0, 0);
    q0 = '{6'h05, 6'h06};
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("t5_push0", push_d0, 1);
    check("t5_data", data_out, 6'h05);
    check("t5_nopop", s_pop0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    // reset right after a grant drops the in-flight word
    q0 = '{6'h07};
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("t6_nopush", push_d0, 0);
    check("t6_idle", idle_out, 1);
    q0.delete(); q1.delete();
    // random traffic
    for (int k = 0; k < 400; k++) begin
      if (q0.size() < 6 && $urandom_range(0, 2) != 0) q0.push_back(DW'($urandom));
      if (q1.size() < 6 && $urandom_range(0, 2) != 0) q1.push_back(DW'($urandom));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
